// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arm, wait for an immediate or rising-threshold trigger, store
// DEPTH decimated samples, then stream the buffer out over a valid/ready handshake.
module adc_capture_ctrl #(
  parameter int DW    = 10,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_1M,
  input  logic          rst_n,
  input  logic [DW-1:0] adc_data,
  input  logic          start,
  input  logic          abort,
  input  logic          trig_mode,
  input  logic [DW-1:0] trig_level,
  input  logic [7:0]    decim,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  // Handshake: a beat transfers on every rising edge where rd_valid && rd_ready.
  // Once rd_valid is high, rd_data/rd_last stay frozen until that transfer; the
  // producer never withdraws a beat except on abort or reset.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          cfg_mode;
  logic [DW-1:0] cfg_level;
  logic [7:0]    cfg_decim;

  logic [DW-1:0] prev;
  logic          prev_vld;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    dcnt;

  logic [DW-1:0] mem [DEPTH];

  logic          fire;
  logic          arm_go;
  logic          trig;
  logic          cap_wr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign fire      = rd_valid & rd_ready;
  assign rd_last   = rd_valid && (rd_ptr == AW'(DEPTH - 1));
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    arm_go    = 1'b0;
    trig      = 1'b0;
    cap_wr    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          arm_go    = 1'b1;
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        // prev_vld keeps the first armed cycle from comparing against a stale sample
        trig = !cfg_mode ||
               (prev_vld && (prev < cfg_level) && (adc_data >= cfg_level));
        if (trig) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        cap_wr = (dcnt == 8'd0);
        if (cap_wr && (wr_ptr == AW'(DEPTH - 1))) state_nxt = S_READOUT;
      end
      S_READOUT: begin
        if (fire && rd_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      arm_go    = 1'b0;
      trig      = 1'b0;
      cap_wr    = 1'b0;
    end
  end

  assign wr_en   = trig | cap_wr;
  assign wr_addr = trig ? '0 : wr_ptr;
  assign rd_addr = fire ? (rd_ptr + AW'(1)) : rd_ptr;

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk_1M) begin
    if (wr_en) mem[wr_addr] <= adc_data;
  end

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      cfg_mode  <= 1'b0;
      cfg_level <= '0;
      cfg_decim <= '0;
      prev      <= '0;
      prev_vld  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dcnt      <= '0;
    end else begin
      if (arm_go) begin
        cfg_mode  <= trig_mode;
        cfg_level <= trig_level;
        cfg_decim <= decim;
        prev_vld  <= 1'b0;
      end
      if (state == S_ARMED) begin
        prev     <= adc_data;
        prev_vld <= 1'b1;
      end
      if (trig) begin
        wr_ptr <= AW'(1);
        rd_ptr <= '0;
        dcnt   <= cfg_decim;
      end else if (state == S_CAPTURE) begin
        if (cap_wr) begin
          wr_ptr <= wr_ptr + AW'(1);
          dcnt   <= cfg_decim;
        end else begin
          dcnt <= dcnt - 8'd1;
        end
      end
      if ((state == S_READOUT) && fire && !rd_last) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        rd_valid <= 1'b0;
      end else if (state == S_READOUT) begin
        if (fire && rd_last) begin
          rd_valid <= 1'b0;
          done     <= 1'b1;
        end else if (!rd_valid || fire) begin
          // first entry loads beat 0; each transfer preloads the next address
          rd_data  <= mem[rd_addr];
          rd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: vector table of ramp captures, sine trigger, abort/reset
// corner sequences, and randomized captures checked against a sample-history model.
`timescale 1ns/1ps
module tb_adc_capture_ctrl;

  localparam int DW    = 10;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  localparam int W_CONST = 0;
  localparam int W_RAMP  = 1;
  localparam int W_SINE  = 2;
  localparam int W_RAND  = 3;

  localparam int ACT_NONE      = 0;
  localparam int ACT_START_MID = 1;
  localparam int ACT_ABORT_CAP = 2;
  localparam int ACT_ABORT_RD  = 3;
  localparam int ACT_RESET_RD  = 4;

  typedef struct {
    bit mode;
    int level;
    int dec;
    bit rnd;
    int exp_lat;
    int exp_first;
    int exp_last;
  } vec_t;

  logic          clk_1M;
  logic          rst_n;
  logic [DW-1:0] adc_data;
  logic          start;
  logic          abort;
  logic          trig_mode;
  logic [DW-1:0] trig_level;
  logic [7:0]    decim;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wave     = W_CONST;
  int ramp0    = 0;
  logic [DW-1:0] const_val = '0;

  // hist[c] is the adc_data value sampled at rising edge number c
  logic [DW-1:0] hist [0:65535];
  logic [DW-1:0] exp_q[$];
  vec_t vecs[7];

  adc_capture_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_1M     (clk_1M),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .start      (start),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .decim      (decim),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_last    (rd_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk_1M = 1'b0;
  always #500 clk_1M = ~clk_1M;

  initial begin
    #60_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // driver: present next ADC sample, record it, advance one clock
  task automatic step();
    logic [DW-1:0] v;
    case (wave)
      W_RAMP:  v = DW'((cyc + 1 - ramp0) & 1023);
      W_SINE:  v = DW'(512 + $rtoi(511.0 * $sin(6.283185307179586 * real'((cyc + 1) % 64) / 64.0)));
      W_RAND:  v = DW'($urandom_range(0, 1023));
      default: v = const_val;
    endcase
    adc_data       = v;
    hist[cyc + 1]  = v;
    @(posedge clk_1M);
    #1;
    cyc++;
  endtask

  task automatic run_capture(input bit mode, input int level, input int dec, input bit rnd,
                             input int act, output int lat, output int first_v,
                             output int last_v, output int nbeats);
    int s;
    int t_trig;
    int budget;
    int stall_errs;
    int done_errs;
    bit stalled;
    lat = -1; first_v = -1; last_v = -1; nbeats = 0;
    stall_errs = 0; done_errs = 0;
    exp_q.delete();
    trig_mode  = mode;
    trig_level = DW'(level);
    decim      = 8'(dec);
    rd_ready   = 1'b0;
    start      = 1'b1;
    s          = cyc + 1;
    ramp0      = s + 1;
    step();
    start      = 1'b0;
    trig_mode  = ~mode;
    trig_level = DW'($urandom_range(0, 1023));
    decim      = 8'($urandom_range(0, 255));
    check("busy_after_start", busy, 1);

    budget = 0;
    while (!rd_valid && budget < 6000) begin
      if (done) done_errs++;
      start = (act == ACT_START_MID) && (cyc == s + 20);
      abort = (act == ACT_ABORT_CAP) && (cyc == s + 100);
      step();
      budget++;
      if (act == ACT_ABORT_CAP && cyc == s + 101) begin
        abort = 1'b0;
        start = 1'b0;
        check("abort_cap_busy", busy, 0);
        check("abort_cap_valid", rd_valid, 0);
        repeat (4) begin
          if (done || busy || rd_valid) done_errs++;
          step();
        end
        check("abort_cap_quiet", done_errs, 0);
        return;
      end
    end
    start = 1'b0;
    if (!rd_valid) begin
      check("first_valid_timeout", 0, 1);
      return;
    end
    lat = cyc - s;

    // reference model: locate the trigger in the sample history, then pick every (dec+1)th sample
    t_trig = -1;
    if (!mode) t_trig = s + 1;
    else begin
      for (int c = s + 2; c <= cyc; c++) begin
        if (int'(hist[c - 1]) < level && int'(hist[c]) >= level) begin
          t_trig = c;
          break;
        end
      end
    end
    if (t_trig < 0) begin
      check("model_trigger_found", 0, 1);
      return;
    end
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(hist[t_trig + k * (dec + 1)]);
    check("first_valid_latency", lat, t_trig + (DEPTH - 1) * (dec + 1) + 1 - s);

    stalled = 1'b0;
    budget  = 0;
    while (nbeats < DEPTH && budget < 4000) begin
      if (done) done_errs++;
      if (stalled && (!rd_valid || rd_data !== exp_q[0])) stall_errs++;
      if (act == ACT_ABORT_RD && nbeats == 50) begin
        abort    = 1'b1;
        rd_ready = 1'b1;
        step();
        abort    = 1'b0;
        rd_ready = 1'b0;
        check("abort_rd_busy", busy, 0);
        check("abort_rd_valid", rd_valid, 0);
        check("abort_rd_done", done, 0);
        repeat (4) begin
          if (done || rd_valid) done_errs++;
          step();
        end
        check("abort_rd_quiet", done_errs, 0);
        return;
      end
      if (act == ACT_RESET_RD && nbeats == 100) begin
        #200;
        rst_n = 1'b0;
        #10;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rd_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (4) begin
          if (done || busy || rd_valid) done_errs++;
          step();
        end
        check("rst_quiet", done_errs, 0);
        return;
      end
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid && rd_ready) begin
        check($sformatf("beat%0d_data", nbeats), rd_data, exp_q[0]);
        check($sformatf("beat%0d_last", nbeats), rd_last, 32'(exp_q.size() == 1));
        if (nbeats == 0) first_v = int'(rd_data);
        last_v = int'(rd_data);
        void'(exp_q.pop_front());
        nbeats++;
      end
      stalled = rd_valid && !rd_ready;
      step();
      budget++;
    end
    rd_ready = 1'b0;
    check("beat_count", nbeats, DEPTH);
    check("done_pulse", done, 1);
    check("busy_low_with_done", busy, 0);
    check("valid_low_with_done", rd_valid, 0);
    step();
    check("done_single_cycle", done, 0);
    check("stall_hold", stall_errs, 0);
    check("no_early_done", done_errs, 0);
  endtask

  initial begin
    int lat, fv, lv, nb;
    // mode, level, decim, random-ready, expected latency / first beat / last beat (ramp from 0)
    vecs[0] = '{1'b0, 0,    0, 1'b0, 257,  0,    255};
    vecs[1] = '{1'b0, 0,    3, 1'b0, 1022, 0,    1020};
    vecs[2] = '{1'b0, 0,    1, 1'b1, 512,  0,    510};
    vecs[3] = '{1'b0, 0,    4, 1'b1, 1277, 0,    251};
    vecs[4] = '{1'b1, 512,  0, 1'b0, 769,  512,  767};
    vecs[5] = '{1'b1, 1,    2, 1'b1, 768,  1,    766};
    vecs[6] = '{1'b1, 1023, 0, 1'b0, 1280, 1023, 254};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; trig_mode = 1'b0;
    trig_level = '0; decim = '0; rd_ready = 1'b0; adc_data = '0;
    step();
    step();
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_last", rd_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    step();
    check("post_reset_busy", busy, 0);

    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", busy, 0);

    for (int i = 0; i < 7; i++) begin
      wave = W_RAMP;
      run_capture(vecs[i].mode, vecs[i].level, vecs[i].dec, vecs[i].rnd, ACT_NONE, lat, fv, lv, nb);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_first", i), fv, vecs[i].exp_first);
      check($sformatf("vec%0d_last", i), lv, vecs[i].exp_last);
      check($sformatf("vec%0d_beats", i), nb, DEPTH);
    end

    // sine, armed while above level: must wait for the next upward crossing
    wave = W_SINE;
    while (((cyc + 1) % 64) != 8) step();
    run_capture(1'b1, 512, 0, 1'b1, ACT_NONE, lat, fv, lv, nb);
    check("sine_first_ge_level", 32'(fv >= 512), 1);
    check("sine_waited_crossing", lat, 312);

    // abort while ARMED
    wave = W_CONST; const_val = 100;
    trig_mode = 1'b1; trig_level = 512; decim = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("armed_busy", busy, 1);
    repeat (5) step();
    check("armed_waiting_valid", rd_valid, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_armed_busy", busy, 0);
    check("abort_armed_valid", rd_valid, 0);
    check("abort_armed_done", done, 0);

    wave = W_RAMP;
    run_capture(1'b0, 0, 0, 1'b0, ACT_ABORT_CAP, lat, fv, lv, nb);
    run_capture(1'b0, 0, 0, 1'b0, ACT_NONE, lat, fv, lv, nb);
    check("after_abort_cap_last", lv, 255);
    run_capture(1'b0, 0, 0, 1'b1, ACT_ABORT_RD, lat, fv, lv, nb);
    run_capture(1'b0, 0, 0, 1'b1, ACT_NONE, lat, fv, lv, nb);
    check("after_abort_rd_beats", nb, DEPTH);
    run_capture(1'b0, 0, 1, 1'b0, ACT_START_MID, lat, fv, lv, nb);
    check("start_mid_last", lv, 510);

    for (int r = 0; r < 5; r++) begin
      wave = W_RAND;
      run_capture(1'($urandom_range(0, 1)), int'($urandom_range(100, 900)),
                  int'($urandom_range(0, 3)), 1'(r % 2), ACT_NONE, lat, fv, lv, nb);
      check($sformatf("rand%0d_beats", r), nb, DEPTH);
    end

    wave = W_RAMP;
    run_capture(1'b1, 300, 0, 1'b1, ACT_RESET_RD, lat, fv, lv, nb);
    run_capture(1'b0, 0, 0, 1'b0, ACT_NONE, lat, fv, lv, nb);
    check("after_reset_first", fv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
